// File: rtl/dcsk_demod_ctrl.sv
// -----------------------------------------------------------------------------
// dcsk_demod_ctrl
//
// Control block for a DCSK receiver. It sits between the chip-product stage and
// the serial-to-parallel output register. Each symbol has two halves of sf_l
// chips. The reference half is written into the variable delay register. The
// correlation half reads it back, and the sign of each chip product is summed
// in an internal +1/-1 majority accumulator. The decided bits are packed into
// frames of FRAME_BITS. A frame is offered with a valid/ready handshake, and
// the block also reports abort and overrun.
//
// Optional feature macro: SOFT_OUT_EN
//   When defined, the block adds the Corr_Sum output, which carries the final
//   accumulator value alongside Demod_Bit_Valid. A zero sum then repeats the
//   previous decided bit instead of giving 0.
//
// Ports:
//   Clk, Rst          clock (rising edge), asynchronous active-high reset
//   Valid             one chip present this cycle
//   Correlated_Bit    sign of reference x data chip product (1 = positive)
//   Spread_Factor     chips per half-symbol, sampled at symbol start only
//   Var_Del_Reg_Addr  delay-register chip address
//   Var_Del_Reg_Load  write current chip into the delay register
//   Var_Del_Reg_Re    read the delay register for correlation
//   Demod_Bit         decided bit, qualified by Demod_Bit_Valid
//   Demod_Bit_Valid   one-cycle strobe
//   STP_Out_Reg_Addr  frame slot of Demod_Bit
//   Frame_Valid       frame complete, held until accepted
//   Frame_Ready       downstream accepts the frame
//   Abort             one-cycle pulse: Valid dropped mid-symbol
//   Overrun           sticky: a frame completed while the previous one was
//                     still unaccepted
//   Corr_Sum          (SOFT_OUT_EN only) final correlation sum
// -----------------------------------------------------------------------------
module dcsk_demod_ctrl #(
    parameter int SF_W         = 5,
    parameter int DEL_ADDR_W   = 4,
    parameter int FRAME_BITS   = 32,
    parameter int FRAME_ADDR_W = $clog2(FRAME_BITS)
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Valid,
    input  logic                         Correlated_Bit,
    input  logic [SF_W-1:0]              Spread_Factor,
    output logic [DEL_ADDR_W-1:0]        Var_Del_Reg_Addr,
    output logic                         Var_Del_Reg_Load,
    output logic                         Var_Del_Reg_Re,
    output logic                         Demod_Bit,
    output logic                         Demod_Bit_Valid,
    output logic [FRAME_ADDR_W-1:0]      STP_Out_Reg_Addr,
    output logic                         Frame_Valid,
    input  logic                         Frame_Ready,
    output logic                         Abort,
`ifdef SOFT_OUT_EN
    output logic signed [DEL_ADDR_W+1:0] Corr_Sum,
`endif
    output logic                         Overrun
);

    localparam int ACC_W  = DEL_ADDR_W + 2;
    localparam int SF_MAX = 2 ** DEL_ADDR_W;

    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;
    localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_MONE = -ACC_W'(1);
    localparam logic [FRAME_ADDR_W-1:0] IDX_LAST = FRAME_ADDR_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REF  = 2'd1,
        S_CORR = 2'd2
    } state_t;

    // Clamp the requested spread factor to [2, 2**DEL_ADDR_W]. The minimum of
    // 2 keeps the last-chip compare (sf_l-1) meaningful for both halves.
    function automatic logic [DEL_ADDR_W:0] clamp_sf(input logic [SF_W-1:0] sf);
        int v;
        v = int'(sf);
        if (v < 2) begin
            v = 2;
        end else if (v > SF_MAX) begin
            v = SF_MAX;
        end
        return (DEL_ADDR_W + 1)'(v);
    endfunction

    state_t                    state_q, state_d;
    logic [DEL_ADDR_W-1:0]     cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [DEL_ADDR_W:0]       sf_l_q, sf_l_d;
    logic [FRAME_ADDR_W-1:0]   idx_q, idx_d;
    logic                      demod_bit_q, demod_bit_d;
    logic                      dbv_q, dbv_d;
    logic [FRAME_ADDR_W-1:0]   stp_addr_q, stp_addr_d;
    logic                      fv_q, fv_d;
    logic                      abort_q, abort_d;
    logic                      overrun_q, overrun_d;
    logic signed [ACC_W-1:0]   corr_sum_q, corr_sum_d;

    logic [DEL_ADDR_W:0]       sf_m1;
    logic                      cnt_last;
    logic signed [ACC_W-1:0]   acc_sum;
    logic                      tie_bit;
    logic                      decided;

    // The counter holds the address of the chip in the current half.
    assign sf_m1    = sf_l_q - 1'b1;
    assign cnt_last = ({1'b0, cnt_q} == sf_m1);

    // The running sum includes the current chip, so the last correlation chip
    // is part of the decision made on the same edge.
    assign acc_sum  = acc_q + (Correlated_Bit ? ACC_ONE : ACC_MONE);

`ifdef SOFT_OUT_EN
    assign tie_bit  = demod_bit_q;
`else
    assign tie_bit  = 1'b0;
`endif

    always_comb begin
        if (acc_sum > ACC_ZERO) begin
            decided = 1'b1;
        end else if (acc_sum == ACC_ZERO) begin
            decided = tie_bit;
        end else begin
            decided = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sf_l_d      = sf_l_q;
        idx_d       = idx_q;
        demod_bit_d = demod_bit_q;
        dbv_d       = 1'b0;
        stp_addr_d  = stp_addr_q;
        fv_d        = fv_q;
        abort_d     = 1'b0;
        overrun_d   = overrun_q;
        corr_sum_d  = corr_sum_q;

        // Accepting the frame clears it unless a new frame lands on the same
        // edge. That case is handled below.
        if (fv_q && Frame_Ready) begin
            fv_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (Valid) begin
                    sf_l_d  = clamp_sf(Spread_Factor);
                    cnt_d   = DEL_ADDR_W'(1);
                    state_d = S_REF;
                end
            end

            S_REF, S_CORR: begin
                if (!Valid) begin
                    // Dropped chip stream: the partial symbol and the partial
                    // frame are both discarded.
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    acc_d       = '0;
                    idx_d       = '0;
                    demod_bit_d = 1'b0;
                    abort_d     = 1'b1;
                end else if (state_q == S_REF) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = S_CORR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_last) begin
                    // The symbol ends here and the next reference half starts
                    // on the very next chip.
                    demod_bit_d = decided;
                    dbv_d       = 1'b1;
                    stp_addr_d  = idx_q;
                    corr_sum_d  = acc_sum;
                    acc_d       = '0;
                    cnt_d       = '0;
                    sf_l_d      = clamp_sf(Spread_Factor);
                    state_d     = S_REF;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        fv_d  = 1'b1;
                        if (fv_q && !Frame_Ready) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sf_l_q      <= '0;
            idx_q       <= '0;
            demod_bit_q <= 1'b0;
            dbv_q       <= 1'b0;
            stp_addr_q  <= '0;
            fv_q        <= 1'b0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
            corr_sum_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sf_l_q      <= sf_l_d;
            idx_q       <= idx_d;
            demod_bit_q <= demod_bit_d;
            dbv_q       <= dbv_d;
            stp_addr_q  <= stp_addr_d;
            fv_q        <= fv_d;
            abort_q     <= abort_d;
            overrun_q   <= overrun_d;
            corr_sum_q  <= corr_sum_d;
        end
    end

    // The delay-register strobes are gated by Rst so that every output drops
    // as soon as reset is asserted, even while Valid is still high.
    assign Var_Del_Reg_Load = Valid && !Rst && (state_q == S_IDLE || state_q == S_REF);
    assign Var_Del_Reg_Re   = Valid && !Rst && (state_q == S_CORR);
    assign Var_Del_Reg_Addr = (state_q == S_IDLE) ? '0 : cnt_q;

    assign Demod_Bit        = demod_bit_q;
    assign Demod_Bit_Valid  = dbv_q;
    assign STP_Out_Reg_Addr = stp_addr_q;
    assign Frame_Valid      = fv_q;
    assign Abort            = abort_q;
    assign Overrun          = overrun_q;

`ifdef SOFT_OUT_EN
    assign Corr_Sum = corr_sum_q;
`endif

endmodule

// File: tb/tb_dcsk_demod_ctrl.sv
module tb_dcsk_demod_ctrl;

    localparam int SF_W         = 5;
    localparam int DEL_ADDR_W   = 4;
    localparam int FRAME_BITS   = 32;
    localparam int FRAME_ADDR_W = $clog2(FRAME_BITS);
    localparam int SF_MAX       = 2 ** DEL_ADDR_W;
`ifdef SOFT_OUT_EN
    localparam int SOFT = 1;
`else
    localparam int SOFT = 0;
`endif

    logic                         Clk = 1'b0;
    logic                         Rst = 1'b1;
    logic                         Valid = 1'b0;
    logic                         Correlated_Bit = 1'b0;
    logic [SF_W-1:0]              Spread_Factor = '0;
    logic                         Frame_Ready = 1'b0;
    logic [DEL_ADDR_W-1:0]        Var_Del_Reg_Addr;
    logic                         Var_Del_Reg_Load;
    logic                         Var_Del_Reg_Re;
    logic                         Demod_Bit;
    logic                         Demod_Bit_Valid;
    logic [FRAME_ADDR_W-1:0]      STP_Out_Reg_Addr;
    logic                         Frame_Valid;
    logic                         Abort;
    logic                         Overrun;
`ifdef SOFT_OUT_EN
    logic signed [DEL_ADDR_W+1:0] Corr_Sum;
`endif

    dcsk_demod_ctrl #(
        .SF_W(SF_W), .DEL_ADDR_W(DEL_ADDR_W),
        .FRAME_BITS(FRAME_BITS), .FRAME_ADDR_W(FRAME_ADDR_W)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Valid(Valid), .Correlated_Bit(Correlated_Bit),
        .Spread_Factor(Spread_Factor), .Var_Del_Reg_Addr(Var_Del_Reg_Addr),
        .Var_Del_Reg_Load(Var_Del_Reg_Load), .Var_Del_Reg_Re(Var_Del_Reg_Re),
        .Demod_Bit(Demod_Bit), .Demod_Bit_Valid(Demod_Bit_Valid),
        .STP_Out_Reg_Addr(STP_Out_Reg_Addr), .Frame_Valid(Frame_Valid),
        .Frame_Ready(Frame_Ready), .Abort(Abort),
`ifdef SOFT_OUT_EN
        .Corr_Sum(Corr_Sum),
`endif
        .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: one position counter that runs over the whole symbol
    // (0 .. 2*sf-1), plus a list of chip products for the correlation half.
    int m_active, m_pos, m_sf, m_bitidx, m_fv, m_ov, m_prev;
    int m_prod[$];
    int e_dbv, e_bit, e_slot, e_abort, e_csum;
    int addr_max;

    function automatic int clamp(input int sf);
        if (sf < 2) return 2;
        if (sf > SF_MAX) return SF_MAX;
        return sf;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_sf = 2; m_bitidx = 0; m_fv = 0; m_ov = 0; m_prev = 0;
        m_prod.delete();
        e_dbv = 0; e_bit = 0; e_slot = 0; e_abort = 0; e_csum = 0;
    endtask

    task automatic apply_reset();
        Rst = 1'b1; Valid = 1'b0; Frame_Ready = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(input int v, input int cb, input int sf, input int fr);
        Valid = v[0]; Correlated_Bit = cb[0]; Spread_Factor = SF_W'(sf); Frame_Ready = fr[0];
        #1;
    endtask

    task automatic check_model();
        int x_load, x_re, x_addr;
        x_load = (Valid && (!m_active || m_pos < m_sf)) ? 1 : 0;
        x_re   = (Valid && m_active && m_pos >= m_sf) ? 1 : 0;
        x_addr = m_active ? (m_pos % m_sf) : 0;
        chk("load", int'(Var_Del_Reg_Load), x_load);
        chk("re", int'(Var_Del_Reg_Re), x_re);
        chk("addr", int'(Var_Del_Reg_Addr), x_addr);
        chk("dbv", int'(Demod_Bit_Valid), e_dbv);
        chk("abort", int'(Abort), e_abort);
        chk("frame_valid", int'(Frame_Valid), m_fv);
        chk("overrun", int'(Overrun), m_ov);
        if (e_dbv != 0) begin
            chk("demod_bit", int'(Demod_Bit), e_bit);
            chk("slot", int'(STP_Out_Reg_Addr), e_slot);
`ifdef SOFT_OUT_EN
            chk("corr_sum", int'(Corr_Sum), e_csum);
`endif
        end
        if (int'(Var_Del_Reg_Addr) > addr_max) addr_max = int'(Var_Del_Reg_Addr);
    endtask

    // Update the model with the inputs of this cycle, then move to the next
    // falling edge.
    task automatic advance();
        int nfv, sum;
        nfv = (m_fv != 0 && !Frame_Ready) ? 1 : m_fv;
        if (m_fv != 0 && Frame_Ready) nfv = 0;
        e_dbv = 0; e_abort = 0;
        if (!m_active) begin
            if (Valid) begin
                m_active = 1; m_sf = clamp(int'(Spread_Factor)); m_pos = 1; m_prod.delete();
            end
        end else if (!Valid) begin
            m_active = 0; m_pos = 0; m_bitidx = 0; m_prev = 0; m_prod.delete();
            e_abort = 1;
        end else begin
            if (m_pos >= m_sf) m_prod.push_back(Correlated_Bit ? 1 : -1);
            if (m_pos == 2 * m_sf - 1) begin
                sum = 0;
                foreach (m_prod[i]) sum += m_prod[i];
                e_bit  = (sum > 0) ? 1 : (sum < 0) ? 0 : (SOFT != 0 ? m_prev : 0);
                m_prev = e_bit;
                e_dbv  = 1; e_slot = m_bitidx; e_csum = sum;
                if (m_bitidx == FRAME_BITS - 1) begin
                    m_bitidx = 0;
                    if (m_fv != 0 && !Frame_Ready) m_ov = 1;
                    nfv = 1;
                end else begin
                    m_bitidx++;
                end
                m_prod.delete(); m_pos = 0; m_sf = clamp(int'(Spread_Factor));
            end else begin
                m_pos++;
            end
        end
        m_fv = nfv;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic step(input int v, input int cb, input int sf, input int fr);
        drive(v, cb, sf, fr);
        check_model();
        advance();
    endtask

    task automatic symbol(input int sf, input int fr);
        for (int k = 0; k < 2 * clamp(sf); k++) step(1, $urandom % 2, sf, fr);
    endtask

    // Counts chips from IDLE to the decision strobe for one spread factor.
    task automatic run_len(input int sf, input int exp_chips, input int exp_amax, input string nm);
        int got;
        got = 0;
        step(0, 0, sf, 0);
        step(0, 0, sf, 0);
        addr_max = 0;
        for (int n = 1; n <= 100; n++) begin
            step(1, $urandom % 2, sf, 0);
            if (Demod_Bit_Valid) begin
                got = n;
                break;
            end
        end
        chk({nm, "_chips"}, got, exp_chips);
        chk({nm, "_addr_max"}, addr_max, exp_amax);
    endtask

    typedef struct {
        int v, cb, sf, fr, load, re, addr, dbv, dbit, slot;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        addr_max = 0;
        // Two SF=4 symbols: products 1,1,0,1 (sum 2) and then 1,0,1,0 (tie).
        tbl.push_back('{1,0,4,0, 1,0,0, 0,0,0});
        tbl.push_back('{1,0,4,0, 1,0,1, 0,0,0});
        tbl.push_back('{1,0,4,0, 1,0,2, 0,0,0});
        tbl.push_back('{1,0,4,0, 1,0,3, 0,0,0});
        tbl.push_back('{1,1,4,0, 0,1,0, 0,0,0});
        tbl.push_back('{1,1,4,0, 0,1,1, 0,0,0});
        tbl.push_back('{1,0,4,0, 0,1,2, 0,0,0});
        tbl.push_back('{1,1,4,0, 0,1,3, 0,0,0});
        tbl.push_back('{1,0,4,0, 1,0,0, 1,1,0});
        tbl.push_back('{1,0,4,0, 1,0,1, 0,0,0});
        tbl.push_back('{1,0,4,0, 1,0,2, 0,0,0});
        tbl.push_back('{1,0,4,0, 1,0,3, 0,0,0});
        tbl.push_back('{1,1,4,0, 0,1,0, 0,0,0});
        tbl.push_back('{1,0,4,0, 0,1,1, 0,0,0});
        tbl.push_back('{1,1,4,0, 0,1,2, 0,0,0});
        tbl.push_back('{1,0,4,0, 0,1,3, 0,0,0});
        tbl.push_back('{0,0,4,0, 0,0,0, 1,SOFT,1});

        apply_reset();
        chk("rst_dbv", int'(Demod_Bit_Valid), 0);
        chk("rst_fv", int'(Frame_Valid), 0);
        chk("rst_slot", int'(STP_Out_Reg_Addr), 0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].cb, tbl[i].sf, tbl[i].fr);
            check_model();
            chk($sformatf("tbl%0d_load", i), int'(Var_Del_Reg_Load), tbl[i].load);
            chk($sformatf("tbl%0d_re", i), int'(Var_Del_Reg_Re), tbl[i].re);
            chk($sformatf("tbl%0d_addr", i), int'(Var_Del_Reg_Addr), tbl[i].addr);
            chk($sformatf("tbl%0d_dbv", i), int'(Demod_Bit_Valid), tbl[i].dbv);
            if (tbl[i].dbv != 0) begin
                chk($sformatf("tbl%0d_bit", i), int'(Demod_Bit), tbl[i].dbit);
                chk($sformatf("tbl%0d_slot", i), int'(STP_Out_Reg_Addr), tbl[i].slot);
            end
            advance();
        end
        chk("tbl_abort_pulse", int'(Abort), 1);

        // Spread-factor clamping: half lengths of 2 and 16 chips.
        run_len(0, 4, 1, "sf0");
        run_len(31, 32, 15, "sf31");
        run_len(8, 16, 7, "sf8");

        // Valid dropped at correlation chip 2 with SF=8.
        step(0, 0, 8, 0);
        step(0, 0, 8, 0);
        for (int k = 0; k < 10; k++) step(1, $urandom % 2, 8, 0);
        step(0, 0, 8, 0);
        chk("abort_pulse", int'(Abort), 1);
        chk("abort_no_dbv", int'(Demod_Bit_Valid), 0);
        drive(1, 1, 8, 0);
        check_model();
        chk("restart_addr", int'(Var_Del_Reg_Addr), 0);
        chk("restart_load", int'(Var_Del_Reg_Load), 1);
        advance();
        for (int k = 1; k < 16; k++) step(1, $urandom % 2, 8, 0);
        chk("restart_dbv", int'(Demod_Bit_Valid), 1);
        chk("restart_slot", int'(STP_Out_Reg_Addr), 0);

        // Frame completion, overrun and accept.
        apply_reset();
        for (int s = 0; s < 32; s++) symbol(2, 0);
        chk("frame1_fv", int'(Frame_Valid), 1);
        chk("frame1_slot", int'(STP_Out_Reg_Addr), 31);
        chk("frame1_ov", int'(Overrun), 0);
        for (int s = 0; s < 32; s++) symbol(2, 0);
        chk("frame2_ov", int'(Overrun), 1);
        chk("frame2_fv", int'(Frame_Valid), 1);
        step(1, 0, 2, 1);
        chk("accept_fv", int'(Frame_Valid), 0);
        chk("accept_ov_sticky", int'(Overrun), 1);
        for (int k = 0; k < 3; k++) step(1, $urandom % 2, 2, 0);
        for (int s = 0; s < 31; s++) symbol(2, 0);
        chk("frame3_fv", int'(Frame_Valid), 1);

        // Asynchronous reset in the middle of a correlation half.
        for (int k = 0; k < 3; k++) step(1, $urandom % 2, 2, 0);
        drive(1, 1, 2, 0);
        check_model();
        chk("pre_rst_re", int'(Var_Del_Reg_Re), 1);
        #2 Rst = 1'b1;
        #1;
        chk("arst_load", int'(Var_Del_Reg_Load), 0);
        chk("arst_re", int'(Var_Del_Reg_Re), 0);
        chk("arst_addr", int'(Var_Del_Reg_Addr), 0);
        chk("arst_fv", int'(Frame_Valid), 0);
        chk("arst_ov", int'(Overrun), 0);
        chk("arst_dbv", int'(Demod_Bit_Valid), 0);
        chk("arst_bit", int'(Demod_Bit), 0);
        chk("arst_abort", int'(Abort), 0);
        @(negedge Clk);
        Rst = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 40) != 0, $urandom % 2, $urandom % 32, ($urandom % 6) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
